// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - bin, one bit per clock, LSB first.
// A single full-subtractor cell feeds a result shift register while a borrow
// flop carries the chain from one bit to the next. A start/ready/done
// handshake frames each operation; the result and flags are held in
// registers and only change when an operation finishes (or on reset).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic             zero
);

    // The counter is one bit wider than strictly needed so it never wraps
    // while counting 0..WIDTH-1.
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] a_sr_q,     a_sr_d;
    logic [WIDTH-1:0] b_sr_q,     b_sr_d;
    logic [WIDTH-1:0] r_sr_q,     r_sr_d;
    logic             borrow_q,   borrow_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             a_msb_q,    a_msb_d;
    logic             b_msb_q,    b_msb_d;
    logic [WIDTH-1:0] diff_q,     diff_d;
    logic             bout_q,     bout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q,     zero_d;

    // Full-subtractor cell outputs for the bit currently at the LSB.
    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] result_next;

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            r_sr_q     <= '0;
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            r_sr_q     <= r_sr_d;
            borrow_q   <= borrow_d;
            cnt_q      <= cnt_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    // Next-state, serial datapath step and result capture on the last bit.
    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        r_sr_d      = r_sr_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        cell_diff   = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
        cell_borrow = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
        result_next = {cell_diff, r_sr_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = A;
                    b_sr_d   = B;
                    r_sr_d   = '0;
                    borrow_d = bin;
                    cnt_d    = '0;
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                r_sr_d   = result_next;
                borrow_d = cell_borrow;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d     = result_next;
                    bout_d     = cell_borrow;
                    overflow_d = (a_msb_q ^ b_msb_q) & (result_next[WIDTH-1] ^ a_msb_q);
                    zero_d     = (result_next == '0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign diff     = diff_q;
    assign bout     = bout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake corner
// cases, exhaustive WIDTH=4 sweep and random WIDTH=8 sweep against an
// arithmetic reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       reset_n;

    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       bin_in;
    logic       ready, busy, done;
    logic [3:0] diff;
    logic       bout, overflow, zero;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       ready8, busy8, done8;
    logic [7:0] diff8;
    logic       bout8, overflow8, zero8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] exp_diff;
        logic       exp_bout;
        logic       exp_ovf;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[7];
    int   order[512];

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .A(a_in), .B(b_in), .bin(bin_in),
        .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout),
        .overflow(overflow), .zero(zero)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .A(a8), .B(b8), .bin(bin8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8),
        .overflow(overflow8), .zero(zero8)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer subtraction, unsigned borrow from the sign of
    // the true result, overflow from the signed result leaving its range.
    // Packed as {zero, overflow, bout, diff[31:0]}.
    function automatic logic [63:0] refModel(input int w, input longint a, input longint b,
                                             input longint c);
        longint m, full, d, sa, sb, sr;
        logic   z, o, bo;
        m    = longint'(1) << w;
        full = a - b - c;
        d    = (full < 0) ? full + m : full;
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sr   = sa - sb - c;
        bo   = (full < 0);
        o    = (sr < -(m / 2)) || (sr >= m / 2);
        z    = (d == 0);
        return {29'b0, z, o, bo, 32'(d)};
    endfunction

    function automatic logic [63:0] packResult4();
        return {29'b0, zero, overflow, bout, 28'b0, diff};
    endfunction

    function automatic logic [63:0] packResult8();
        return {29'b0, zero8, overflow8, bout8, 24'b0, diff8};
    endfunction

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one 4-bit op from IDLE (called just after a falling edge),
    // scramble the inputs after capture, and count falling edges until done.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic c,
                                 output int lat);
        a_in   = a;
        b_in   = b;
        bin_in = c;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a_in   = 4'($urandom);
        b_in   = 4'($urandom);
        bin_in = 1'($urandom);
        lat    = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Full 4-bit operation with latency, result and post-done handshake checks
    task automatic runOp4(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic [63:0] exp);
        int lat;
        applyStimulus(a, b, c, lat);
        checkOutput({name, " latency"}, 64'(lat), 64'd5);
        checkOutput({name, " result{z,ovf,bout,diff}"}, packResult4(), exp);
        @(negedge clk);
        checkOutput({name, " idle{ready,busy,done}"}, {61'b0, ready, busy, done}, 64'b100);
    endtask

    // Full 8-bit operation on the second instance
    task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int lat;
        a8     = a;
        b8     = b;
        bin8   = c;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        lat    = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
        checkOutput("w8 latency", 64'(lat), 64'd9);
        checkOutput("w8 result{z,ovf,bout,diff}", packResult8(), refModel(8, longint'(a), longint'(b), longint'(c)));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int dones;
        logic [3:0] got;
        logic [63:0] exp;

        vecs[0] = '{4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'd0, 4'd8, 1'b0, 4'h8, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
        start8  = 1'b0; a8   = '0; b8   = '0; bin8   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset {ready,busy,done}", {61'b0, ready, busy, done}, 64'b100);
        checkOutput("reset result", packResult4(), 64'd0);
        checkOutput("reset w8 {ready,busy,done}", {61'b0, ready8, busy8, done8}, 64'b100);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            exp = {29'b0, vecs[i].exp_zero, vecs[i].exp_ovf, vecs[i].exp_bout, 28'b0, vecs[i].exp_diff};
            runOp4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, exp);
        end

        // start while busy is ignored; inputs wiggle after capture
        a_in = 4'd9; b_in = 4'd2; bin_in = 1'b0; start = 1'b1;
        @(posedge clk);
        dones = 0;
        got   = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                got   = diff;
                start = 1'b0;
            end else if (busy) begin
                start = 1'b1;
                a_in  = 4'($urandom);
                b_in  = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        checkOutput("ignore-start done count", 64'(dones), 64'd1);
        checkOutput("ignore-start diff", 64'(got), 64'd7);

        // Reset mid-operation discards the result
        a_in = 4'd6; b_in = 4'd1; bin_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset {ready,busy,done}", {61'b0, ready, busy, done}, 64'b100);
        checkOutput("midreset diff", 64'(diff), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("midreset no done", 64'(dones), 64'd0);

        // Back-to-back operations with start held high
        start = 1'b1;
        for (int op = 0; op < 4; op++) begin
            logic [3:0] a, b;
            logic       c;
            checkOutput("b2b ready", {63'b0, ready}, 64'd1);
            a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
            a_in = a; b_in = b; bin_in = c;
            @(posedge clk);
            lat = -1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (done) begin
                    lat = i;
                    break;
                end
            end
            checkOutput("b2b latency", 64'(lat), 64'd5);
            checkOutput("b2b result", packResult4(), refModel(4, longint'(a), longint'(b), longint'(c)));
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);

        // Exhaustive WIDTH=4 sweep in shuffled order
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a, b;
            logic       c;
            a = 4'(order[i] & 15);
            b = 4'((order[i] >> 4) & 15);
            c = 1'((order[i] >> 8) & 1);
            runOp4("sweep4", a, b, c, refModel(4, longint'(a), longint'(b), longint'(c)));
        end

        // Random WIDTH=8 sweep, including extremes
        runOp8(8'h00, 8'hFF, 1'b1);
        runOp8(8'h80, 8'h7F, 1'b0);
        runOp8(8'h7F, 8'h80, 1'b0);
        for (int i = 0; i < 200; i++) begin
            runOp8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle bit-serial subtractor computing A - B - bin, the borrow-chain counterpart to the team's ripple-carry adder. It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. A start/ready/done handshake lets a controller FSM launch operations and collect a registered difference plus status flags. It sits in the datapath where area matters more than latency.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2 to 32).

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  launch request; sampled only when ready=1.
A  input  WIDTH  minuend; captured on the accepted start edge.
B  input  WIDTH  subtrahend; captured on the accepted start edge.
bin  input  1  borrow-in; captured on the accepted start edge.
ready  output  1  high in IDLE; block accepts start.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse; result outputs valid and newly updated.
diff  output  WIDTH  registered difference, (A - B - bin) mod 2^WIDTH.
bout  output  1  final borrow: 1 iff unsigned A < B + bin.
overflow  output  1  two's-complement overflow: (A[msb] != B[msb]) and (diff[msb] != A[msb]).
zero  output  1  diff == 0.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, shift registers, bit counter, and borrow FF cleared. Outputs: ready=1, busy=0, done=0, diff=0, bout=0, overflow=0, zero=0. Takes effect mid-operation; the in-flight result is discarded and no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1. On an edge with start=1, load a_sr<=A, b_sr<=B, borrow<=bin, cnt<=0, save A[msb] and B[msb] for overflow, then go to SHIFT. With start=0, stay in IDLE.
- SHIFT: busy=1, ready=0. On each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - d shifts into the MSB of the result shift register; a_sr and b_sr shift right; cnt increments.
- On the edge processing bit WIDTH-1: diff <= full result, bout <= final borrow, overflow and zero computed from that result, state goes to DONE.
- DONE: done=1 and ready=0 for exactly one cycle. The next edge goes unconditionally to IDLE.
- Latency: start accepted at edge k; done is high in the cycle between edges k+WIDTH and k+WIDTH+1. Next start is accepted at edge k+WIDTH+1 or later. Throughput is one op per WIDTH+1 cycles.
- start while in SHIFT or DONE is ignored and not queued. A, B, and bin may change freely after capture without affecting the result.
- diff, bout, overflow, and zero hold their values until the next DONE entry or reset. They never show partial results.
- Arithmetic is unsigned modular. bout carries the unsigned comparison; overflow carries the signed interpretation. Both are always produced.
- The bit counter is $clog2(WIDTH)+1 bits and never wraps during an operation.

Test Plan:
- WIDTH=4, A=7, B=3, bin=0, start pulse -> done exactly 5 cycles after the start edge; diff=4, bout=0, overflow=0, zero=0; ready=1 on the following cycle.
- A=3, B=7, bin=0 -> diff=0xC, bout=1, overflow=0, zero=0.
- A=8, B=1, bin=0 (signed -8 - 1) -> diff=7, bout=0, overflow=1. Then A=5, B=5 -> diff=0, zero=1, bout=0, overflow=0.
- A=0, B=0, bin=1 -> diff=0xF, bout=1, overflow=0.
- Start A=9, B=2; while busy, pulse start with A=1, B=1 and change A/B every cycle -> single done; diff=7; no second done pulse.
- Start A=6, B=1; drop reset_n for 1 cycle after 2 SHIFT cycles -> immediately ready=1, diff=0, no done pulse. Then run back-to-back ops (start held high through DONE) -> each op takes 5 cycles and results are correct with no overlap.
- Random exhaustive sweep of all 512 (A, B, bin) combinations at WIDTH=4 and a random sweep at WIDTH=8 -> compare every result against a reference model.
